// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART responder for the CPU data bus.
//   Window 0x40000018..0x40000023 (decode on addr[31:2]):
//     TXD 0x18  W: byte to send (dropped while busy)  R: 0
//     RXD 0x1C  R: {24'h0, rx_byte}; a read clears rx_valid
//     CON 0x20  R: {28'h0, frame_err, overrun, tx_busy, rx_valid}
//               W: W1C, bit2 clears overrun, bit3 clears frame_err
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low
//   rd, wr     - CPU MemRd / MemWr
//   addr       - CPU byte address
//   wdata      - CPU store data
//   rdata      - combinational read data (0 when rd=0 or outside window)
//   rx         - asynchronous serial input (16x oversampled)
//   tx         - registered serial output
module uart_mmio #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx
);

  localparam int BIT = 16 * DIV;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(BIT);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic          sel_txd, sel_rxd, sel_con;
  logic          rxd_read, con_wr, tx_accept, tx_busy;
  logic [DW-1:0] tcnt;
  logic          tick;

  tx_state_t     tx_state;
  logic [BW-1:0] tx_timer;
  logic          bit_end;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic          rx_meta, rx_s;
  logic [3:0]    rx_ticks;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, overrun, frame_err;

  logic          unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign sel_txd   = (addr[31:2] == 30'h1000_0006);
  assign sel_rxd   = (addr[31:2] == 30'h1000_0007);
  assign sel_con   = (addr[31:2] == 30'h1000_0008);
  assign rxd_read  = rd && sel_rxd;
  assign con_wr    = wr && sel_con;
  assign tx_busy   = (tx_state != TX_IDLE);
  assign tx_accept = wr && sel_txd && !tx_busy;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd)      rdata = {24'h0, rx_byte};
      else if (sel_con) rdata = {28'h0, frame_err, overrun, tx_busy, rx_valid};
    end
  end

  // Free-running oversample tick shared by the receiver.
  assign tick = (tcnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Transmitter runs its own BIT-clock timer, restarted on acceptance,
  // so every bit is exactly BIT clocks regardless of tick phase.
  assign bit_end = (tx_timer == BW'(BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state != TX_IDLE) tx_timer <= bit_end ? '0 : tx_timer + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_accept) begin
            tx_shift <= wdata[7:0];
            tx       <= 1'b0;
            tx_timer <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: if (bit_end) begin
          tx       <= tx_shift[0];
          tx_idx   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (bit_end) begin
          tx       <= tx_shift[1];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_idx   <= tx_idx + 1'b1;
          if (tx_idx == 3'd7) begin
            tx       <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: if (bit_end) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver. Clears are applied first so same-cycle sets win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta   <= 1'b0;
      rx_s      <= 1'b0;
      rx_state  <= RX_IDLE;
      rx_ticks  <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (rxd_read)            rx_valid  <= 1'b0;
      if (con_wr && wdata[2])  overrun   <= 1'b0;
      if (con_wr && wdata[3])  frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_ticks <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (tick) begin
          if (rx_ticks == 4'd7) begin
            rx_ticks <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_ticks <= rx_ticks + 1'b1;
          end
        end
        RX_DATA: if (tick) begin
          rx_ticks <= rx_ticks + 1'b1;
          if (rx_ticks == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_ticks <= rx_ticks + 1'b1;
          if (rx_ticks == 4'd15) begin
            if (rx_s) begin
              // A same-cycle RXD read frees the holding register.
              if (rx_valid && !rxd_read) begin
                overrun <= 1'b1;
              end else begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
              end
              rx_state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: if (rx_s) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
